// File: rtl/banco_registradores.sv
// Integer register file x0..x31 feeding the ULA operand ports.
// After reset an internal sequencer zeroes x1..x31, one register per clock,
// and holds busy high until the bank contents are valid.
module banco_registradores #(
  parameter int BITS   = 64,
  parameter bit BYPASS = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [BITS-1:0] din,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [BITS-1:0] douta,
  output logic [BITS-1:0] doutb,
  output logic            busy
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [4:0]      idx, idx_nxt;
  // x0 is hard-wired zero, so storage starts at x1
  logic [BITS-1:0] regs [31:1];

  logic clr_en;   // this edge clears reg[idx]
  logic wr_en;    // this edge commits the write-back port
  logic fwd_en;   // write-back data may be forwarded to the read ports

  assign clr_en = (state == CLEAR);
  assign wr_en  = (state == READY) && we && (rd != 5'd0);
  assign fwd_en = we && (rd != 5'd0) && !busy;

  // State register: reset (from any state) restarts the clear at x1
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= 5'd1;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state: walk idx 1..31, the edge clearing x31 releases the bank
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (state == CLEAR) begin
      idx_nxt = idx + 5'd1;
      if (idx == 5'd31) state_nxt = READY;
    end
  end

  // Output decode: bank unusable while clearing
  always_comb begin
    busy = (state == CLEAR);
  end

  // Per-register storage: cleared by the sequencer or written back;
  // a reset edge leaves contents untouched
  for (genvar i = 1; i < 32; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!reset) begin
        if (clr_en && (idx == 5'(i)))
          regs[i] <= '0;
        else if (wr_en && (rd == 5'(i)))
          regs[i] <= din;
      end
    end
  end

  // Read mux; index 0 falls through to zero
  function automatic logic [BITS-1:0] rd_mux(input logic [4:0] sel);
    logic [BITS-1:0] v;
    v = '0;
    for (int i = 1; i < 32; i++)
      if (sel == 5'(i)) v = regs[i];
    return v;
  endfunction

  // Operand outputs: forced 0 while clearing, optional same-cycle forwarding
  always_comb begin
    douta = '0;
    doutb = '0;
    if (!busy) begin
      douta = rd_mux(rs1);
      doutb = rd_mux(rs2);
      if (BYPASS && fwd_en && (rd == rs1)) douta = din;
      if (BYPASS && fwd_en && (rd == rs2)) doutb = din;
    end
  end

endmodule
